// File: rtl/shift_reg_pkg.sv
// Shared mode encodings and sizing helper for the universal shift register.
// Imported by the top so ports and the counter width agree.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Bits needed to hold a shift count from 0 up to and including w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/reg_bit_cell.sv
// Single clearable D flop with true and complement outputs; one-edge latency.
// Clear is asynchronous active-low and forces the parameterised reset value.
module reg_bit_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_d,
  output logic o_q,
  output logic o_q_bar
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q     = r_q;
  assign o_q_bar = ~r_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold / shift right / shift left / load, optional rotate.
// One-edge latency; counts shifts since the last load and pulses DONE once per full word.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int              CW        = cnt_w(WIDTH)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             ROT,
  input  logic             SER_IN_R,
  input  logic             SER_IN_L,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_BAR,
  output logic             SER_OUT_R,
  output logic             SER_OUT_L,
  output logic [CW-1:0]    CNT,
  output logic             DONE
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_shift;
  logic             w_load;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  always_comb begin
    w_q_nxt = w_q;
    w_shift = 1'b0;
    w_load  = 1'b0;
    if (EN) begin
      case (MODE)
        MODE_SHR: begin
          w_q_nxt = {(ROT ? w_q[0] : SER_IN_R), w_q[WIDTH-1:1]};
          w_shift = 1'b1;
        end
        MODE_SHL: begin
          w_q_nxt = {w_q[WIDTH-2:0], (ROT ? w_q[WIDTH-1] : SER_IN_L)};
          w_shift = 1'b1;
        end
        MODE_LOAD: begin
          w_q_nxt = D;
          w_load  = 1'b1;
        end
        default: w_q_nxt = w_q;
      endcase
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    reg_bit_cell #(
      .RESET_VAL (RESET_VAL[gi])
    ) u_cell (
      .i_clk   (CLK),
      .i_clr_n (CLR),
      .i_d     (w_q_nxt[gi]),
      .o_q     (w_q[gi]),
      .o_q_bar (Q_BAR[gi])
    );
  end

  // Counter saturates at WIDTH, so DONE can fire only on the single step into WIDTH.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_cnt <= '0;
      end else if (w_shift && (r_cnt != CNT_MAX)) begin
        r_cnt  <= r_cnt + 1'b1;
        r_done <= (r_cnt == (CNT_MAX - 1'b1));
      end
    end
  end

  assign Q         = w_q;
  assign SER_OUT_R = w_q[0];
  assign SER_OUT_L = w_q[WIDTH-1];
  assign CNT       = r_cnt;
  assign DONE      = r_done;

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal register that succeeds the single-bit clearable D flip-flop. It is WIDTH bits wide and supports hold, shift right, shift left and parallel load, with optional rotate. It also tracks shifts since the last load and pulses DONE when a full word has been serialised. It sits in the datapath as the general storage/serialiser element, built from per-bit clearable flops.

Parameters:
WIDTH, 8, register width in bits; legal range 2..32
RESET_VAL, {WIDTH{1'b0}}, value Q takes while CLR is low

Ports:
CLK  input  1  rising-edge clock
CLR  input  1  asynchronous active-low clear
EN  input  1  clock enable; 0 forces hold, overriding MODE
MODE  input  2  00 HOLD, 01 SHR, 10 SHL, 11 LOAD
ROT  input  1  1 = rotate (wrap end bit), 0 = shift in serial input
SER_IN_R  input  1  serial input entering the MSB on SHR
SER_IN_L  input  1  serial input entering the LSB on SHL
D  input  WIDTH  parallel load data
Q  output  WIDTH  register contents
Q_BAR  output  WIDTH  bitwise complement of Q, always equal to ~Q
SER_OUT_R  output  1  Q[0] (bit leaving on SHR)
SER_OUT_L  output  1  Q[WIDTH-1] (bit leaving on SHL)
CNT  output  $clog2(WIDTH+1)  shifts since last load, saturating at WIDTH
DONE  output  1  one-cycle pulse when CNT reaches WIDTH

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low: CLR=0 acts immediately, independent of CLK.
- Reset values while CLR=0: Q=RESET_VAL, Q_BAR=~RESET_VAL, CNT=0, DONE=0.
- Release of CLR takes effect at the next rising CLK edge; no recovery cycle is inserted.
- All state updates occur on the rising CLK edge. Latency is one edge from input to Q.
- EN=0: Q, CNT hold; DONE=0.
- EN=1, MODE=00 HOLD: Q and CNT hold; DONE=0.
- EN=1, MODE=11 LOAD: Q<=D; CNT<=0; DONE<=0.
- EN=1, MODE=01 SHR: Q<={in, Q[WIDTH-1:1]}. The new MSB is Q[0] if ROT=1, else SER_IN_R.
- EN=1, MODE=10 SHL: Q<={Q[WIDTH-2:0], in}. The new LSB is Q[WIDTH-1] if ROT=1, else SER_IN_L.
- Counter on every shift (SHR or SHL):
  - If CNT<WIDTH, CNT<=CNT+1.
  - If that increment makes CNT==WIDTH, DONE<=1 for exactly that one cycle.
  - At CNT==WIDTH, further shifts still move data; CNT stays at WIDTH and DONE does not re-pulse.
- Shift direction may change between cycles. CNT counts shifts in either direction without distinction.
- A LOAD on the same edge as the WIDTH-th shift would be is a LOAD: CNT=0, no DONE.
- A shift immediately after DONE starts no new count; only a LOAD rearms DONE.
- CLR asserted mid-shift or mid-load: it wins over everything. The in-flight edge's update is discarded.
- Serial outputs are combinational taps of registered Q, so they are glitch-free relative to CLK.
- DONE is registered.

Decomposition:
- Shared package shift_reg_pkg:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - counter-width function cnt_w(WIDTH)=$clog2(WIDTH+1).
- One natural sub-module, reg_bit_cell: a single clearable D flop with Q and Q_BAR, reset value selectable by parameter. It is instantiated WIDTH times in a generate loop.
- The next-state mux, counter and DONE logic live in the top.

Test Plan (all with WIDTH=8, RESET_VAL=0):
1. CLR=0 mid-cycle with CLK low, after Q=8'hA5: Q goes 8'h00 and Q_BAR goes 8'hFF immediately with no edge; CNT=0, DONE=0.
2. LOAD D=8'hA5, then 8 SHR with ROT=0, SER_IN_R=1:
   - Q sequence is D2, E9, F4, FA, FD, FE, FF, FF;
   - SER_OUT_R before each shift is 1,0,1,0,0,1,0,1;
   - DONE=1 only in the cycle after the 8th shift; CNT=8 and stays 8 after a 9th shift.
3. LOAD 8'h81, then SHL with ROT=1 three times: Q is 03, 06, 0C. Then SHR with ROT=1 once: Q is 06. CNT=4, no DONE.
4. LOAD 8'h3C, EN=0 with MODE=01 for 5 cycles: Q stays 3C, CNT stays 0. Then MODE=00 with EN=1: Q still holds 3C.
5. LOAD 8'hFF, 7 SHL with SER_IN_L=0, then LOAD 8'h5A on the 8th edge: Q=5A, CNT=0, DONE never asserts. Next 8 shifts produce one DONE.
6. Assert CLR during the 4th of 8 shifts after LOAD 8'hF0: Q=00 and CNT=0 immediately. After release, LOAD 8'h0F followed by 8 shifts yields DONE on schedule.
